// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared immediate-encoding constants, state enum and field helpers
package imm_pkg;

  // ImmSrc mode encoding shared with the extender decode
  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_DP1 = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;
  localparam logic [1:0] IMM_ILL = 2'b11;

  // Result field widths
  localparam int VAL_W  = 32;
  localparam int ENC_W  = 24;
  localparam int ROT_W  = 4;
  localparam int IMM8_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Data-processing immediate field: {12'b0, rot, imm8}
  function automatic logic [ENC_W-1:0] dp_field(input logic [ROT_W-1:0] rot,
                                                input logic [IMM8_W-1:0] imm8);
    return {{(ENC_W-ROT_W-IMM8_W){1'b0}}, rot, imm8};
  endfunction

  // A branch offset fits imm24 when word aligned and bits 31:26 replicate bit 25
  function automatic logic br_ok(input logic [VAL_W-1:0] v);
    return (v[1:0] == 2'b00) && (v[31:26] == {6{v[25]}});
  endfunction

endpackage

// File: rtl/imm_rot_check.sv
// rtl/imm_rot_check.sv - tests one rotation candidate: rotl(value, 2r) fits in 8 bits
module imm_rot_check
  import imm_pkg::*;
(
  input  logic [VAL_W-1:0]  value,
  input  logic [ROT_W-1:0]  r,
  output logic              hit,
  output logic [IMM8_W-1:0] imm8
);

  logic [4:0]       w_sh;
  logic [VAL_W-1:0] w_t;

  // Even rotate amount; a right shift by 32 yields zero, so r=0 passes value through
  assign w_sh = {r, 1'b0};
  assign w_t  = (value << w_sh) | (value >> (6'd32 - {1'b0, w_sh}));

  assign hit  = (w_t[VAL_W-1:IMM8_W] == '0);
  assign imm8 = w_t[IMM8_W-1:0];

endmodule

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - inverse immediate extender: value/offset to rot+imm8 or imm24
module imm_encoder
  import imm_pkg::*;
#(
  parameter int N_ROT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VAL_W-1:0]  value,
  input  logic [1:0]        mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ENC_W-1:0]  enc,
  output logic              ok,
  output logic              busy
);

  localparam logic [ROT_W-1:0] LAST_ROT = ROT_W'(N_ROT - 1);

  state_t             r_state;
  logic [VAL_W-1:0]   r_value;
  logic [ROT_W-1:0]   r_rot;
  logic [ENC_W-1:0]   r_enc;
  logic               r_ok;

  logic [VAL_W-1:0]   w_chk_value;
  logic [ROT_W-1:0]   w_chk_rot;
  logic               w_hit;
  logic [IMM8_W-1:0]  w_imm8;

  // Candidate 0 is tested straight from the request in the accept cycle, so a
  // match at rotation k is reported k+1 cycles after accept; SEARCH then walks
  // the registered copy from rotation 1 upward.
  assign w_chk_value = (r_state == IDLE) ? value : r_value;
  assign w_chk_rot   = (r_state == IDLE) ? '0 : r_rot;

  imm_rot_check u_rot_check (
    .value (w_chk_value),
    .r     (w_chk_rot),
    .hit   (w_hit),
    .imm8  (w_imm8)
  );

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == SEARCH);
  assign out_valid = (r_state == DONE);
  assign enc       = r_enc;
  assign ok        = r_ok;

  // Control FSM: accept, rotation search, result hold until consumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_value <= '0;
      r_rot   <= '0;
      r_enc   <= '0;
      r_ok    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_value <= value;
            r_rot   <= '0;
            if (mode == IMM_BR) begin
              r_enc   <= br_ok(value) ? value[25:2] : '0;
              r_ok    <= br_ok(value);
              r_state <= DONE;
            end else if (mode == IMM_ILL) begin
              r_enc   <= '0;
              r_ok    <= 1'b0;
              r_state <= DONE;
            end else if (w_hit) begin
              r_enc   <= dp_field('0, w_imm8);
              r_ok    <= 1'b1;
              r_state <= DONE;
            end else if (N_ROT <= 1) begin
              r_enc   <= '0;
              r_ok    <= 1'b0;
              r_state <= DONE;
            end else begin
              r_rot   <= ROT_W'(1);
              r_state <= SEARCH;
            end
          end
        end
        SEARCH: begin
          if (w_hit) begin
            r_enc   <= dp_field(r_rot, w_imm8);
            r_ok    <= 1'b1;
            r_rot   <= '0;
            r_state <= DONE;
          end else if (r_rot == LAST_ROT) begin
            r_enc   <= '0;
            r_ok    <= 1'b0;
            r_rot   <= '0;
            r_state <= DONE;
          end else begin
            r_rot   <= r_rot + ROT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - scoreboard bench for imm_encoder
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] value = 32'h0;
  logic [1:0]  mode = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] enc;
  logic        ok;
  logic        busy;

  imm_encoder #(.N_ROT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .value     (value),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .enc       (enc),
    .ok        (ok),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [23:0] enc;
    logic        ok;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t q[$];
  bit   seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare each presented result against the head of the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      seen = 1'b0;
    end else if (out_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got enc=%0h ok=%0b expected no result", enc, ok);
      end else begin
        if (!seen) begin
          chk({q[0].name, "_enc"}, 32'(enc), 32'(q[0].enc));
          chk({q[0].name, "_ok"}, 32'(ok), 32'(q[0].ok));
          chk({q[0].name, "_latency"}, cyc - q[0].acc + 1, q[0].lat);
          seen = 1'b1;
        end
        if (out_ready) begin
          chk({q[0].name, "_enc_at_handshake"}, 32'(enc), 32'(q[0].enc));
          chk({q[0].name, "_ok_at_handshake"}, 32'(ok), 32'(q[0].ok));
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Called just after a rising edge; the request is accepted on the next edge
  task automatic issue(input logic [31:0] v, input logic [1:0] m, input logic [23:0] e_enc,
                       input logic e_ok, input int e_lat, input bit push, input string name);
    exp_t e;
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    value    = v;
    mode     = m;
    if (push) begin
      e.enc  = e_enc;
      e.ok   = e_ok;
      e.lat  = e_lat;
      e.acc  = cyc + 1;
      e.name = name;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    value    = 32'hDEAD_BEEF;
    mode     = 2'b11;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d pending results expected 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic run(input logic [31:0] v, input logic [1:0] m, input logic [23:0] e_enc,
                     input logic e_ok, input int e_lat, input string name);
    issue(v, m, e_enc, e_ok, e_lat, 1'b1, name);
    drain(name);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    bit flag;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_enc", 32'(enc), 32'd0);
    chk("rst_ok", 32'(ok), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    //  value          mode   enc          ok    lat  name
    run(32'h0000_00FF, 2'b00, 24'h0000FF, 1'b1, 1,  "dp_ff");
    run(32'hFF00_0000, 2'b00, 24'h0004FF, 1'b1, 5,  "dp_ff_r4");
    run(32'h0000_0104, 2'b01, 24'h000F41, 1'b1, 16, "dp_104_r15");
    run(32'h0000_0000, 2'b00, 24'h000000, 1'b1, 1,  "dp_zero");
    run(32'h0000_0F00, 2'b00, 24'h000C0F, 1'b1, 13, "dp_f00_r12");
    run(32'h0000_03FC, 2'b00, 24'h000FFF, 1'b1, 16, "dp_3fc_r15");
    run(32'hFFFF_FFF8, 2'b10, 24'hFFFFFE, 1'b1, 1,  "br_neg8");
    run(32'h01FF_FFFC, 2'b10, 24'h7FFFFF, 1'b1, 1,  "br_maxpos");
    run(32'h0200_0000, 2'b10, 24'h000000, 1'b0, 1,  "br_range");
    run(32'h0000_0006, 2'b10, 24'h000000, 1'b0, 1,  "br_misalign");
    run(32'h0000_00FF, 2'b11, 24'h000000, 1'b0, 1,  "illegal");

    // Miss: full 16-candidate search, no accept possible meanwhile
    issue(32'h0000_0102, 2'b00, 24'h000000, 1'b0, 16, 1'b1, "dp_miss");
    flag = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (!busy || in_ready) flag = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("dp_miss_busy_no_ready", 32'(flag), 32'd1);
    chk("dp_miss_done_in_ready", 32'(in_ready), 32'd0);
    drain("dp_miss");

    // Consumer stall: result held stable, no accept, then back-to-back request
    out_ready = 1'b0;
    issue(32'h0000_00FF, 2'b00, 24'h0000FF, 1'b1, 1, 1'b1, "hold");
    flag = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!out_valid || in_ready || enc !== 24'h0000FF || ok !== 1'b1) flag = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("hold_stable", 32'(flag), 32'd1);
    out_ready = 1'b1;
    drain("hold");
    run(32'hFF00_0000, 2'b00, 24'h0004FF, 1'b1, 5, "b2b");

    // Asynchronous reset while evaluating rotation 7
    issue(32'h0000_0102, 2'b00, 24'h000000, 1'b0, 16, 1'b0, "rst_mid");
    repeat (6) @(posedge clk);
    #3;
    chk("rst_mid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_enc", 32'(enc), 32'd0);
    chk("rst_mid_ok", 32'(ok), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    run(32'hFF00_0000, 2'b00, 24'h0004FF, 1'b1, 5, "after_rst");

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
